d_sram_to_sram_like: RTL and testbench

//  Data-side bridge between the core's SRAM-style memory port and the sram-like bus that feeds the AXI interface.
//  - Upstream (core): mem_enM, mem_wenM, aluoutM, mem_write_dataM. Downstream: bus req/addr_ok/data_ok handshake.
//  - Runs a per-access FSM and returns read data to the core.
//  - Drives d_stall to freeze the pipeline until the access completes.
//  - Holds the completed result until the whole pipeline (longest_stall) is released.

---
 rtl/d_sram_to_sram_like.sv | 89 ++++++++
 tb/tb_d_sram_to_sram_like.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/d_sram_to_sram_like.sv
// Data-side bridge: turns the core's single-cycle SRAM port into a req/addr_ok/data_ok
// transaction and stalls the pipeline until the transfer has completed.
module d_sram_to_sram_like #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter bit READ_ALIGN = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    data_sram_en,
    input  logic [DATA_WIDTH/8-1:0] data_sram_wen,
    input  logic [ADDR_WIDTH-1:0]   data_sram_addr,
    input  logic [DATA_WIDTH-1:0]   data_sram_wdata,
    output logic [DATA_WIDTH-1:0]   data_sram_rdata,
    output logic                    d_stall,
    input  logic                    longest_stall,
    output logic                    data_req,
    output logic                    data_wr,
    output logic [1:0]              data_size,
    output logic [ADDR_WIDTH-1:0]   data_addr,
    output logic [DATA_WIDTH-1:0]   data_wdata,
    input  logic                    data_addr_ok,
    input  logic                    data_data_ok,
    input  logic [DATA_WIDTH-1:0]   data_rdata
);
    typedef enum logic [1:0] {IDLE, WAIT_DATA, DONE} state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    req;

    // Transfer size from the byte-enable pattern; reads and odd patterns use a full word.
    function automatic logic [1:0] size_of(input logic [DATA_WIDTH/8-1:0] wen);
        case (wen)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: size_of = 2'd0;
            4'b0011, 4'b1100:                   size_of = 2'd1;
            default:                            size_of = 2'd2;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        req     = 1'b0;
        case (state_q)
            IDLE: begin
                req = data_sram_en;
                if (data_sram_en && data_addr_ok) begin
                    if (data_data_ok) begin
                        state_d = DONE;
                        rdata_d = data_rdata;
                    end else begin
                        state_d = WAIT_DATA;
                    end
                end
            end
            WAIT_DATA: begin
                // The core may drop en here; the accepted transfer still runs to completion.
                if (data_data_ok) begin
                    state_d = DONE;
                    rdata_d = data_rdata;
                end
            end
            DONE: begin
                if (!longest_stall) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign data_req        = req & ~rst;
    assign d_stall         = ~rst & (((state_q == IDLE) & data_sram_en) | (state_q == WAIT_DATA));
    assign data_sram_rdata = rdata_q;
    assign data_wr         = |data_sram_wen;
    assign data_wdata      = data_sram_wdata;
    assign data_size       = size_of(data_sram_wen);
    assign data_addr       = (!data_wr && READ_ALIGN) ? {data_sram_addr[ADDR_WIDTH-1:2], 2'b00}
                                                      : data_sram_addr;
endmodule

// File: tb/tb_d_sram_to_sram_like.sv
// Bench for d_sram_to_sram_like: cycle-driven bus responder plus a queue of expected read data.
module tb_d_sram_to_sram_like;
    logic        clk = 1'b0;
    logic        rst;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;
    logic        d_stall;
    logic        longest_stall;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [31:0] exp_q[$];

    d_sram_to_sram_like #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .READ_ALIGN(1'b1)) dut (
        .clk(clk), .rst(rst),
        .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen),
        .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
        .data_sram_rdata(data_sram_rdata), .d_stall(d_stall),
        .longest_stall(longest_stall), .data_req(data_req), .data_wr(data_wr),
        .data_size(data_size), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata)
    );

    always #5 clk = ~clk;

    // One access: addr_ok offered from cycle aw, data_ok dw cycles after the address handshake,
    // then ls cycles of longest_stall in DONE (with stray bus strobes) and one release cycle.
    task automatic run_access(input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] bdata, input int aw, input int dw, input int ls,
                              output int hs, output int stalls, output int reqs,
                              output int done_reqs, output int done_stalls,
                              output logic [1:0] sz_or, output logic [31:0] addr0,
                              output logic wr0, output logic [31:0] wdata0,
                              output logic [31:0] rd_done, output bit tmo);
        int  k;
        int  t_hs;
        bit  got;
        hs = 0; stalls = 0; reqs = 0; done_reqs = 0; done_stalls = 0;
        sz_or = 2'd0; addr0 = '0; wr0 = 1'b0; wdata0 = '0; rd_done = '0;
        tmo = 1'b0; k = 0; t_hs = -1; got = 1'b0;
        while (!got && !tmo) begin
            @(posedge clk); #1;
            data_sram_en    = 1'b1;
            data_sram_wen   = wen;
            data_sram_addr  = addr;
            data_sram_wdata = wdata;
            longest_stall   = 1'b1;
            data_addr_ok    = (t_hs < 0) && (k >= aw);
            data_data_ok    = ((t_hs < 0) && (k >= aw) && (dw == 0)) || ((t_hs >= 0) && (k >= t_hs + dw));
            data_rdata      = data_data_ok ? bdata : 32'h0BAD_0BAD;
            @(negedge clk);
            if (k == 0) begin
                addr0 = data_addr; wr0 = data_wr; wdata0 = data_wdata;
            end
            if (data_req) begin
                reqs++;
                sz_or = sz_or | data_size;
            end
            if (d_stall) stalls++;
            if (data_req && data_addr_ok) begin
                hs++;
                t_hs = k;
            end
            if (data_data_ok && t_hs >= 0) got = 1'b1;
            k++;
            if (k > 60) tmo = 1'b1;
        end
        for (int i = 0; i <= ls; i++) begin
            @(posedge clk); #1;
            longest_stall = (i < ls);
            data_addr_ok  = 1'b1;
            data_data_ok  = 1'b1;
            data_rdata    = 32'h5555_AAAA;
            @(negedge clk);
            if (data_req) done_reqs++;
            if (d_stall) done_stalls++;
            rd_done = data_sram_rdata;
        end
        @(posedge clk); #1;
        data_sram_en = 1'b0; data_sram_wen = 4'b0000;
        data_addr_ok = 1'b0; data_data_ok = 1'b0; longest_stall = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; data_sram_en = 1'b1; data_sram_wen = 4'b0000; data_sram_addr = 32'h0;
        data_sram_wdata = 32'h0; longest_stall = 1'b0; data_addr_ok = 1'b0;
        data_data_ok = 1'b0; data_rdata = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total_cnt++; if (d_stall !== 1'b0) $display("FAIL reset_stall got %b want 0", d_stall); else pass_cnt++;
        total_cnt++; if (data_req !== 1'b0) $display("FAIL reset_req got %b want 0", data_req); else pass_cnt++;
        total_cnt++; if (data_sram_rdata !== 32'h0) $display("FAIL reset_rdata got %h want 0", data_sram_rdata); else pass_cnt++;
        @(posedge clk); #1;
        rst = 1'b0; data_sram_en = 1'b0;
        @(negedge clk);
        total_cnt++; if (d_stall !== 1'b0 || data_req !== 1'b0) $display("FAIL idle_en0 stall=%b req=%b want 0/0", d_stall, data_req); else pass_cnt++;
    endtask

    task automatic test_size_map();
        logic [3:0] wens [7] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b0101};
        logic [1:0] szs  [7] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd2};
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            data_sram_en = 1'b0; data_sram_wen = wens[i]; data_sram_addr = 32'h0000_0003;
            @(negedge clk);
            total_cnt++;
            if (data_size !== szs[i] || data_wr !== 1'b1 || data_addr !== 32'h0000_0003)
                $display("FAIL size_map wen=%b got size=%0d wr=%b addr=%h want size=%0d wr=1 addr=00000003",
                         wens[i], data_size, data_wr, data_addr, szs[i]);
            else pass_cnt++;
        end
        @(posedge clk); #1;
        data_sram_wen = 4'b0000;
    endtask

    task automatic test_read_wait();
        int hs, st, rq, drq, dst; logic [1:0] sz; logic [31:0] a0, w0, rd; logic wr; bit tmo;
        exp_q.push_back(32'hDEAD_BEEF);
        run_access(4'b0000, 32'h1000_0006, 32'h0, 32'hDEAD_BEEF, 1, 2, 0,
                   hs, st, rq, drq, dst, sz, a0, wr, w0, rd, tmo);
        total_cnt++; if (tmo) $display("FAIL t1_timeout got timeout want completion"); else pass_cnt++;
        total_cnt++; if (a0 !== 32'h1000_0004 || wr !== 1'b0 || sz !== 2'd2)
            $display("FAIL t1_fields got addr=%h wr=%b size=%0d want 10000004/0/2", a0, wr, sz); else pass_cnt++;
        total_cnt++; if (st !== 4 || dst !== 0) $display("FAIL t1_stall got %0d+%0d want 4+0", st, dst); else pass_cnt++;
        total_cnt++; if (hs !== 1 || rq !== 2) $display("FAIL t1_handshake got hs=%0d req=%0d want 1/2", hs, rq); else pass_cnt++;
        total_cnt++; if (rd !== exp_q[0]) $display("FAIL t1_rdata got %h want %h", rd, exp_q[0]); else pass_cnt++;
        void'(exp_q.pop_front());
        @(negedge clk);
        total_cnt++; if (d_stall !== 1'b0 || data_req !== 1'b0 || data_sram_rdata !== 32'hDEAD_BEEF)
            $display("FAIL t1_after got stall=%b req=%b rdata=%h want 0/0/deadbeef", d_stall, data_req, data_sram_rdata); else pass_cnt++;
    endtask

    task automatic test_write_fast();
        int hs, st, rq, drq, dst; logic [1:0] sz; logic [31:0] a0, w0, rd; logic wr; bit tmo;
        exp_q.push_back(32'h0000_0001);
        run_access(4'b1100, 32'h0000_0102, 32'h1234_5678, 32'h0000_0001, 0, 0, 0,
                   hs, st, rq, drq, dst, sz, a0, wr, w0, rd, tmo);
        total_cnt++; if (wr !== 1'b1 || sz !== 2'd1 || a0 !== 32'h0000_0102 || w0 !== 32'h1234_5678)
            $display("FAIL t2_fields got wr=%b size=%0d addr=%h wdata=%h want 1/1/00000102/12345678", wr, sz, a0, w0); else pass_cnt++;
        total_cnt++; if (st !== 1 || dst !== 0 || hs !== 1 || tmo)
            $display("FAIL t2_stall got stall=%0d+%0d hs=%0d tmo=%b want 1+0/1/0", st, dst, hs, tmo); else pass_cnt++;
        total_cnt++; if (rd !== exp_q[0]) $display("FAIL t2_rdata got %h want %h", rd, exp_q[0]); else pass_cnt++;
        void'(exp_q.pop_front());
    endtask

    task automatic test_hold_done();
        int hs, st, rq, drq, dst; logic [1:0] sz; logic [31:0] a0, w0, rd; logic wr; bit tmo;
        exp_q.push_back(32'hA5A5_0F0F);
        run_access(4'b0000, 32'h0000_2000, 32'h0, 32'hA5A5_0F0F, 0, 1, 3,
                   hs, st, rq, drq, dst, sz, a0, wr, w0, rd, tmo);
        total_cnt++; if (drq !== 0 || dst !== 0 || hs !== 1 || tmo)
            $display("FAIL t3_done got req=%0d stall=%0d hs=%0d tmo=%b want 0/0/1/0", drq, dst, hs, tmo); else pass_cnt++;
        total_cnt++; if (rd !== exp_q[0]) $display("FAIL t3_rdata got %h want %h", rd, exp_q[0]); else pass_cnt++;
        void'(exp_q.pop_front());
        @(posedge clk); #1;
        data_sram_en = 1'b1; data_sram_addr = 32'h0000_3000;
        @(negedge clk);
        total_cnt++; if (data_req !== 1'b1 || d_stall !== 1'b1)
            $display("FAIL t3_idle_again got req=%b stall=%b want 1/1", data_req, d_stall); else pass_cnt++;
        @(posedge clk); #1;
        data_sram_en = 1'b0;
    endtask

    task automatic test_addr_wait();
        int hs, st, rq, drq, dst; logic [1:0] sz; logic [31:0] a0, w0, rd; logic wr; bit tmo;
        exp_q.push_back(32'h0000_00C3);
        run_access(4'b0001, 32'h0000_0401, 32'h0000_00AB, 32'h0000_00C3, 5, 1, 0,
                   hs, st, rq, drq, dst, sz, a0, wr, w0, rd, tmo);
        total_cnt++; if (rq !== 6 || sz !== 2'd0 || wr !== 1'b1 || a0 !== 32'h0000_0401)
            $display("FAIL t4_req got req=%0d size_or=%0d wr=%b addr=%h want 6/0/1/00000401", rq, sz, wr, a0); else pass_cnt++;
        total_cnt++; if (st !== 7 || hs !== 1 || tmo)
            $display("FAIL t4_stall got stall=%0d hs=%0d tmo=%b want 7/1/0", st, hs, tmo); else pass_cnt++;
        total_cnt++; if (rd !== exp_q[0]) $display("FAIL t4_rdata got %h want %h", rd, exp_q[0]); else pass_cnt++;
        void'(exp_q.pop_front());
    endtask

    task automatic test_en_drop();
        @(posedge clk); #1;
        data_sram_en = 1'b1; data_sram_wen = 4'b0000; data_sram_addr = 32'h0000_5000;
        longest_stall = 1'b1; data_addr_ok = 1'b1;
        exp_q.push_back(32'h7777_1234);
        @(posedge clk); #1;
        data_sram_en = 1'b0; data_addr_ok = 1'b0;
        @(negedge clk);
        total_cnt++; if (d_stall !== 1'b1 || data_req !== 1'b0)
            $display("FAIL en_drop_wait got stall=%b req=%b want 1/0", d_stall, data_req); else pass_cnt++;
        @(posedge clk); #1;
        data_data_ok = 1'b1; data_rdata = 32'h7777_1234;
        @(posedge clk); #1;
        data_data_ok = 1'b0; longest_stall = 1'b0;
        @(negedge clk);
        total_cnt++; if (d_stall !== 1'b0 || data_sram_rdata !== exp_q[0])
            $display("FAIL en_drop_done got stall=%b rdata=%h want 0/%h", d_stall, data_sram_rdata, exp_q[0]); else pass_cnt++;
        void'(exp_q.pop_front());
        @(posedge clk); #1;
        @(negedge clk);
        total_cnt++; if (data_req !== 1'b0 || d_stall !== 1'b0)
            $display("FAIL en_drop_idle got req=%b stall=%b want 0/0", data_req, d_stall); else pass_cnt++;
    endtask

    task automatic test_reset_wait();
        @(posedge clk); #1;
        data_sram_en = 1'b1; data_sram_wen = 4'b0000; data_sram_addr = 32'h0000_6000;
        longest_stall = 1'b1; data_addr_ok = 1'b1;
        @(posedge clk); #1;
        data_addr_ok = 1'b0; data_sram_en = 1'b0; rst = 1'b1;
        @(negedge clk);
        total_cnt++; if (d_stall !== 1'b0 || data_req !== 1'b0)
            $display("FAIL t5_in_rst got stall=%b req=%b want 0/0", d_stall, data_req); else pass_cnt++;
        @(posedge clk); #1;
        rst = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        total_cnt++; if (d_stall !== 1'b0 || data_req !== 1'b0 || data_sram_rdata !== 32'h0)
            $display("FAIL t5_after_rst got stall=%b req=%b rdata=%h want 0/0/0", d_stall, data_req, data_sram_rdata); else pass_cnt++;
        @(posedge clk); #1;
        data_data_ok = 1'b0; longest_stall = 1'b0;
        @(negedge clk);
        total_cnt++; if (data_sram_rdata !== 32'h0) $display("FAIL t5_stray got rdata=%h want 0", data_sram_rdata); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int hs, st, rq, drq, dst; logic [1:0] sz; logic [31:0] a0, w0, rd; logic wr; bit tmo;
        logic [31:0] bd [2] = '{32'h1111_AAAA, 32'h2222_BBBB};
        logic [31:0] ad [2] = '{32'h0000_7003, 32'h0000_8004};
        exp_q.push_back(bd[0]);
        exp_q.push_back(bd[1]);
        for (int i = 0; i < 2; i++) begin
            run_access(4'b0000, ad[i], 32'h0, bd[i], i, 1, 0,
                       hs, st, rq, drq, dst, sz, a0, wr, w0, rd, tmo);
            total_cnt++; if (hs !== 1 || tmo || a0 !== {ad[i][31:2], 2'b00})
                $display("FAIL b2b_hs%0d got hs=%0d tmo=%b addr=%h want 1/0/%h", i, hs, tmo, a0, {ad[i][31:2], 2'b00}); else pass_cnt++;
            total_cnt++; if (rd !== exp_q[0]) $display("FAIL b2b_rdata%0d got %h want %h", i, rd, exp_q[0]); else pass_cnt++;
            void'(exp_q.pop_front());
        end
    endtask

    initial begin
        test_reset();
        test_size_map();
        test_read_wait();
        test_write_fast();
        test_hold_done();
        test_addr_wait();
        test_en_drop();
        test_reset_wait();
        test_back_to_back();
        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no finish want finish before 200000");
        $fatal(1, "watchdog expired");
    end
endmodule
